gray_to_binary_tracker: RTL and testbench
=========================================

Name: gray_to_binary_tracker

Overview:
- Receive-side counterpart of the team's binary-to-Gray encoder.
- Accepts a stream of W-bit Gray-coded position samples, for example from a Gray-encoded pointer or a rotary/position sensor.
- Decodes each sample to binary in a 2-stage pipeline and classifies each step against the previous sample: up, down, hold or illegal jump.
- Keeps a signed wrap (turn) counter and a saturating error counter for the downstream control logic.

Parameters:
- W, 4, width of the Gray input and binary output.
- CW, 8, width of the wrap counter (two's complement, wraps modulo 2^CW).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  g carries a new sample this cycle. No backpressure; one sample per cycle max.
- g  input  W  Gray-coded sample.
- clr  input  1  synchronous clear of counters, sticky flag and tracking state.
- out_valid  output  1  one-cycle strobe; b and the step flags are valid.
- b  output  W  decoded binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- up  output  1  step was +1 mod 2^W.
- dn  output  1  step was -1 mod 2^W.
- step_err  output  1  step magnitude was >1 (illegal jump).
- err_sticky  output  1  set by any step_err; held until clr or reset.
- err_cnt  output  8  count of step_err events, saturating at 255.
- wrap_cnt  output  CW  +1 on each up-step from 2^W-1 to 0; -1 on each down-step from 0 to 2^W-1.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs, pipeline registers and the reference register go to 0.
  - State goes to INIT.
  - Anything in flight is discarded.
- Pipeline:
  - Stage 1 registers g and in_valid.
  - Stage 2 decodes the Gray value (XOR prefix from the MSB), classifies the step and registers all outputs.
  - Latency: in_valid at cycle n gives out_valid at cycle n+2. Throughput 1 sample/cycle.
  - Gaps in in_valid simply produce gaps in out_valid.
- State machine:
  - INIT: no reference sample yet. The next stage-2 sample gives out_valid=1 with up=dn=step_err=0. It becomes the reference and the state moves to TRACK.
  - TRACK: compute d = b_new - b_ref mod 2^W.
    - d=0: hold; all flags 0.
    - d=1: up=1.
    - d=2^W-1: dn=1.
    - Any other d: step_err=1, err_sticky=1, err_cnt increments (saturating).
  - In all TRACK cases b_ref <= b_new, so the tracker resyncs after an error.
  - TRACK never returns to INIT except on clr or reset.
- Wrap counting:
  - Only on up or dn steps with b_ref=2^W-1 and b_new=0 (increment), or b_ref=0 and b_new=2^W-1 (decrement).
  - Wraps modulo 2^CW with no saturation.
- Flag timing: up, dn and step_err are valid only while out_valid=1 and are 0 otherwise. err_sticky, err_cnt and wrap_cnt are levels.
- W=1 edge case: d is 0 or 1 (=2^W-1). A change reports up=1, dn=0; no step_err is possible.
- clr (synchronous):
  - Same cycle: err_cnt, err_sticky and wrap_cnt go to 0.
  - A stage-2 sample present in the clr cycle is handled as an INIT sample: flags 0, it becomes the reference, state goes to TRACK.
  - Without a sample, the state goes to INIT.
  - clr has priority over counter updates in the same cycle.
  - The stage-1 contents are unaffected by clr.
- Reset mid-stream: output registers go to 0 immediately (async). The first sample after release is an INIT sample.

Test Plan:
- Count-up: W=4, in_valid=1 for 4 cycles with g=0000,0001,0011,0010.
  - Expect out_valid on cycles 2..5 with b=0,1,2,3.
  - First has all flags 0; the next three have up=1.
  - err_cnt=0.
- Wrap both ways: g=1001 (b=14), 1000 (b=15), 0000 (b=0), then 1000 (b=15).
  - Expect up,up,dn after the first.
  - wrap_cnt goes 0→1 on 15→0, then back to 0 on 0→15.
  - A further down-wrap from 0 on a fresh clr gives wrap_cnt=0xFF.
- Illegal jump: b=2 (g=0011) then b=6 (g=0101).
  - Expect step_err=1, up=dn=0, err_sticky=1, err_cnt=1.
  - Next g=0100 (b=7) gives up=1 (resynced).
- Hold and gaps: g=0110 (b=4), idle 3 cycles, g=0110 again.
  - Exactly two out_valid strobes, spaced 4 cycles apart.
  - Second has all flags 0.
- Saturation and clr: 300 alternating jumps between b=0 and b=8.
  - err_cnt holds at 255.
  - clr pulse gives err_cnt=0, err_sticky=0, wrap_cnt=0; the next sample has all flags 0 (INIT).
- Async reset mid-stream: assert rst_n=0 between clock edges while a sample is in stage 1.
  - All outputs 0 immediately; the in-flight sample is never output.
  - After release, the first sample has all flags 0.

Source files
------------

// File: rtl/gray_to_binary_tracker.sv
`default_nettype none
// ============================================================================
// Module   : gray_to_binary_tracker
// Brief    : Two-stage Gray-to-binary decoder with up/down/hold/jump step
//            classification, signed wrap counter and saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
module gray_to_binary_tracker #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  g,
    input  logic          clr,
    output logic          out_valid,
    output logic [W-1:0]  b,
    output logic          up,
    output logic          dn,
    output logic          step_err,
    output logic          err_sticky,
    output logic [7:0]    err_cnt,
    output logic [CW-1:0] wrap_cnt
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [W-1:0] c_pos_max = '1;
    localparam logic [W-1:0] c_one     = W'(1);
    localparam logic [W-1:0] c_zero    = '0;

    state_t         r_state;
    logic           r_s1_valid;
    logic [W-1:0]   r_s1_g;
    logic [W-1:0]   r_ref;

    logic [W-1:0]   w_b;
    logic [W-1:0]   w_d;
    logic           w_up;
    logic           w_dn;
    logic           w_jump;
    logic           w_wrap_inc;
    logic           w_wrap_dec;

    // Prefix XOR from the MSB down: each binary bit folds in one more Gray bit.
    always_comb begin
        logic w_acc;
        w_acc = 1'b0;
        w_b   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            w_acc  = w_acc ^ r_s1_g[i];
            w_b[i] = w_acc;
        end
    end

    // Up is tested before down so that W=1 reports a change as up.
    always_comb begin
        w_d        = w_b - r_ref;
        w_up       = (w_d == c_one);
        w_dn       = !w_up && (w_d == c_pos_max);
        w_jump     = (w_d != c_zero) && !w_up && !w_dn;
        w_wrap_inc = w_up && (r_ref == c_pos_max) && (w_b == c_zero);
        w_wrap_dec = w_dn && (r_ref == c_zero) && (w_b == c_pos_max);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
            r_ref      <= '0;
            out_valid  <= 1'b0;
            b          <= '0;
            up         <= 1'b0;
            dn         <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_g     <= g;
            out_valid  <= r_s1_valid;
            up         <= 1'b0;
            dn         <= 1'b0;
            step_err   <= 1'b0;

            if (r_s1_valid) begin
                b <= w_b;
            end

            if (clr) begin
                // A sample coinciding with clr is treated as a fresh reference.
                err_cnt    <= '0;
                err_sticky <= 1'b0;
                wrap_cnt   <= '0;
                if (r_s1_valid) begin
                    r_ref   <= w_b;
                    r_state <= ST_TRACK;
                end else begin
                    r_state <= ST_INIT;
                end
            end else if (r_s1_valid) begin
                r_ref   <= w_b;
                r_state <= ST_TRACK;
                if (r_state == ST_TRACK) begin
                    up       <= w_up;
                    dn       <= w_dn;
                    step_err <= w_jump;
                    if (w_jump) begin
                        err_sticky <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                    if (w_wrap_inc) begin
                        wrap_cnt <= wrap_cnt + CW'(1);
                    end else if (w_wrap_dec) begin
                        wrap_cnt <= wrap_cnt - CW'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_to_binary_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_to_binary_tracker
// Brief    : Self-checking bench for gray_to_binary_tracker with a behavioural
//            step/wrap/error model driven by directed and random streams.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gray_to_binary_tracker;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam int M  = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  g = '0;
    logic          clr = 1'b0;
    logic          out_valid;
    logic [W-1:0]  b;
    logic          up;
    logic          dn;
    logic          step_err;
    logic          err_sticky;
    logic [7:0]    err_cnt;
    logic [CW-1:0] wrap_cnt;

    gray_to_binary_tracker #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .g          (g),
        .clr        (clr),
        .out_valid  (out_valid),
        .b          (b),
        .up         (up),
        .dn         (dn),
        .step_err   (step_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [24:0] dut_vec;
    logic [24:0] exp_vec;
    assign dut_vec = {out_valid, b, up, dn, step_err, err_sticky, err_cnt, wrap_cnt};

    // Input history ring: the sample reaching the output stage is the one
    // driven one tick earlier than the current edge.
    logic         hv[8];
    logic [W-1:0] hg[8];

    bit  has_ref;
    int  m_ref, m_b, m_cnt, m_wrap;
    bit  m_sticky, e_ov, e_up, e_dn, e_err;

    function automatic int gray2bin(input int gv);
        int r = 0;
        for (int s = 0; s < W; s++) r = r ^ (gv >> s);
        return r & (M - 1);
    endfunction

    task automatic model_reset();
        has_ref = 0; m_ref = 0; m_b = 0; m_cnt = 0; m_wrap = 0;
        m_sticky = 0; e_ov = 0; e_up = 0; e_dn = 0; e_err = 0;
        for (int i = 0; i < 8; i++) begin hv[i] = 1'b0; hg[i] = '0; end
        exp_vec = '0;
    endtask

    task automatic model_step(input logic sv, input logic [W-1:0] sg, input logic c);
        int nb, d;
        e_ov = sv; e_up = 0; e_dn = 0; e_err = 0;
        nb = gray2bin(int'(sg));
        if (c) begin
            m_cnt = 0; m_sticky = 0; m_wrap = 0;
            if (sv) begin m_b = nb; m_ref = nb; has_ref = 1; end
            else has_ref = 0;
        end else if (sv) begin
            m_b = nb;
            if (has_ref) begin
                d = (nb - m_ref + M) % M;
                if (d == 1) begin
                    e_up = 1;
                    if (m_ref == M - 1 && nb == 0) m_wrap = (m_wrap + 1) % 256;
                end else if (d == M - 1) begin
                    e_dn = 1;
                    if (m_ref == 0 && nb == M - 1) m_wrap = (m_wrap + 255) % 256;
                end else if (d != 0) begin
                    e_err = 1; m_sticky = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_ref = nb; has_ref = 1;
        end
        exp_vec = {e_ov, W'(m_b), e_up, e_dn, e_err, m_sticky, 8'(m_cnt), CW'(m_wrap)};
    endtask

    // Drives one cycle of inputs, then advances the model for the edge just taken.
    task automatic tick(input logic v, input logic [W-1:0] gv, input logic c);
        in_valid = v; g = gv; clr = c;
        hv[cyc % 8] = v; hg[cyc % 8] = gv;
        @(posedge clk);
        @(negedge clk);
        model_step(hv[(cyc + 7) % 8], hg[(cyc + 7) % 8], c);
        cyc++;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if (dut_vec !== 25'd0) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 25'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        logic [W-1:0] seq[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        int idx[$]; int bs[$]; int ups = 0;
        for (int i = 0; i < 6; i++) begin
            tick(i < 4, (i < 4) ? seq[i] : 4'b0000, 1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL count_up i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            if (out_valid) begin idx.push_back(i); bs.push_back(int'(b)); ups += int'(up); end
        end
        checks++;
        if (idx.size() != 4 || idx[0] != 1 || idx[3] != 4 || bs[0] != 0 || bs[1] != 1 || bs[2] != 2 || bs[3] != 3) begin
            failures++; $display("FAIL count_up_seq got strobes=%0d first_at=%0d exp strobes=4 first_at=1 b=0,1,2,3", idx.size(), (idx.size() > 0) ? idx[0] : -1);
        end
        checks++;
        if (ups != 3 || err_cnt !== 8'd0) begin
            failures++; $display("FAIL count_up_flags got ups=%0d err_cnt=%0d exp ups=3 err_cnt=0", ups, err_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] seq[4] = '{4'b1001, 4'b1000, 4'b0000, 4'b1000};
        int wr[$]; int fl[$];
        tick(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(i < 4, (i < 4) ? seq[i] : 4'b0000, 1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL wrap i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            if (out_valid) begin wr.push_back(int'(wrap_cnt)); fl.push_back(int'({up, dn})); end
        end
        checks++;
        if (wr.size() != 4 || wr[0] != 0 || wr[1] != 0 || wr[2] != 1 || wr[3] != 0 ||
            fl[0] != 0 || fl[1] != 2 || fl[2] != 2 || fl[3] != 1) begin
            failures++; $display("FAIL wrap_both_ways got strobes=%0d wrap_end=%0d exp strobes=4 wrap 0,0,1,0 flags init,up,up,dn", wr.size(), wrap_cnt);
        end
        tick(1'b0, '0, 1'b1);
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b1, 4'b1000, 1'b0);
        tick(1'b0, '0, 1'b0);
        checks++;
        if (dut_vec !== exp_vec || dn !== 1'b1) begin
            failures++; $display("FAIL wrap_down_step got=%h exp=%h", dut_vec, exp_vec);
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if (wrap_cnt !== 8'hFF) begin
            failures++; $display("FAIL wrap_down_ff got=%h exp=ff", wrap_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] seq[3] = '{4'b0011, 4'b0101, 4'b0100};
        int fl[$];
        tick(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(i < 3, (i < 3) ? seq[i] : 4'b0000, 1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL illegal i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            if (out_valid) fl.push_back(int'({up, dn, step_err}));
        end
        checks++;
        if (fl.size() != 3 || fl[0] != 0 || fl[1] != 1 || fl[2] != 4 || err_cnt !== 8'd1 || err_sticky !== 1'b1) begin
            failures++; $display("FAIL illegal_jump got strobes=%0d err_cnt=%0d sticky=%0d exp strobes=3 err_cnt=1 sticky=1", fl.size(), err_cnt, err_sticky);
        end
    endtask

    task automatic test_hold_gaps();
        int idx[$];
        tick(1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(i == 0 || i == 4, 4'b0110, 1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL hold_gaps i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            if (out_valid) begin
                idx.push_back(i);
                if (idx.size() == 2) begin
                    checks++;
                    if ({up, dn, step_err} !== 3'b000 || b !== 4'd4) begin
                        failures++; $display("FAIL hold_flags got b=%0d flags=%b exp b=4 flags=000", b, {up, dn, step_err});
                    end
                end
            end
        end
        checks++;
        if (idx.size() != 2 || idx[1] - idx[0] != 4) begin
            failures++; $display("FAIL hold_spacing got strobes=%0d exp strobes=2 spacing=4", idx.size());
        end
    endtask

    task automatic test_saturation_clr();
        tick(1'b0, '0, 1'b1);
        for (int i = 0; i < 302; i++) begin
            tick(i < 300, (i % 2 == 0) ? 4'b0000 : 4'b1100, 1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL saturation i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
        end
        checks++;
        if (err_cnt !== 8'd255 || err_sticky !== 1'b1) begin
            failures++; $display("FAIL saturation_hold got err_cnt=%0d exp 255", err_cnt);
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (err_cnt !== 8'd0 || err_sticky !== 1'b0 || wrap_cnt !== 8'd0) begin
            failures++; $display("FAIL clr_counters got err_cnt=%0d sticky=%0d wrap=%0d exp 0", err_cnt, err_sticky, wrap_cnt);
        end
        tick(1'b1, 4'b0011, 1'b0);
        tick(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {up, dn, step_err} !== 3'b000 || dut_vec !== exp_vec) begin
            failures++; $display("FAIL clr_init_sample got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        int cur = 0; int r;
        logic v, c;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 3 && r <= 5) cur = (cur + 1) % M;
            else if (r >= 6 && r <= 8) cur = (cur + M - 1) % M;
            else if (r == 9) cur = $urandom_range(0, M - 1);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 29) == 0);
            tick(v, W'(cur ^ (cur >> 1)), c);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_async_reset();
        int idx[$];
        tick(1'b1, 4'b0011, 1'b0);
        tick(1'b1, 4'b0010, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 25'd0) begin
            failures++; $display("FAIL async_reset_immediate got=%h exp=0", dut_vec);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, '0, 1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL async_reset_hold i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(i < 2, (i == 0) ? 4'b1001 : 4'b1000, 1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL async_reset_after i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            if (out_valid) idx.push_back(i);
            if (out_valid && idx.size() == 1) begin
                checks++;
                if (b !== 4'd14 || {up, dn, step_err} !== 3'b000) begin
                    failures++; $display("FAIL async_reset_first got b=%0d flags=%b exp b=14 flags=000", b, {up, dn, step_err});
                end
            end
        end
        checks++;
        if (idx.size() != 2) begin
            failures++; $display("FAIL async_reset_inflight got strobes=%0d exp 2", idx.size());
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_illegal();
        test_hold_gaps();
        test_saturation_clr();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
